// File: rtl/tow_pkg.sv
// Shared types and defaults for the Tug-of-War scorer.
// Holds the FSM state encoding and board geometry helpers.
package tow_pkg;

    localparam int NUM_POS_DEF = 7;
    localparam int SETTLE_DEF  = 16;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        READY  = 2'd1,
        SETTLE = 2'd2,
        WIN    = 2'd3
    } state_t;

    function automatic int centre(input int n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/tow_scorer.sv
// Tug-of-War scorer: moves the rope marker on arbitrated pushes,
// latches a win at either end and re-arms the buttons after release.
module tow_scorer
    import tow_pkg::*;
#(
    parameter int NUM_POS    = NUM_POS_DEF,
    parameter int SETTLE_CYC = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               tie,
    input  logic               right,
    output logic               clr,
    output logic [NUM_POS-1:0] leds,
    output logic               win_left,
    output logic               win_right
);

    localparam int PW = $clog2(NUM_POS);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [PW-1:0] PMAX = PW'(NUM_POS - 1);
    localparam logic [PW-1:0] PCTR = PW'(centre(NUM_POS));
    localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYC - 1);

    localparam logic [NUM_POS-1:0] ONE = {{(NUM_POS-1){1'b0}}, 1'b1};

    state_t        state, state_n;
    logic [PW-1:0] pos, pos_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          push_q;
    logic          edge_hit;

    assign edge_hit = push & ~push_q;

    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = cnt;
        unique case (state)
            CLEAR: begin
                state_n = READY;
                cnt_n   = '0;
            end
            READY: begin
                if (edge_hit) begin
                    if (!tie) begin
                        pos_n = right ? pos + PW'(1) : pos - PW'(1);
                    end
                    cnt_n = '0;
                    if (pos_n == '0 || pos_n == PMAX) begin
                        state_n = WIN;
                    end else begin
                        state_n = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // any bounce restarts the release window
                if (push) begin
                    cnt_n = '0;
                end else if (cnt == CMAX) begin
                    cnt_n   = '0;
                    state_n = CLEAR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WIN: begin
                state_n = WIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            pos       <= PCTR;
            cnt       <= '0;
            push_q    <= 1'b0;
            leds      <= ONE << PCTR;
            clr       <= 1'b1;
            win_left  <= 1'b0;
            win_right <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            cnt       <= cnt_n;
            push_q    <= push;
            leds      <= ONE << pos_n;
            // buttons stay disarmed for the whole win
            clr       <= (state_n == CLEAR) || (state_n == WIN);
            win_left  <= (state_n == WIN) && (pos_n == '0);
            win_right <= (state_n == WIN) && (pos_n == PMAX);
        end
    end

endmodule

// File: tb/tb_tow_scorer.sv
// Randomised and directed bench for tow_scorer against a
// game-level reference model of the rope position.
module tb_tow_scorer;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       tie;
    logic       right;
    logic       clr;
    logic [6:0] leds;
    logic       win_left;
    logic       win_right;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tow_scorer #(.NUM_POS(7), .SETTLE_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .tie       (tie),
        .right     (right),
        .clr       (clr),
        .leds      (leds),
        .win_left  (win_left),
        .win_right (win_right)
    );

    // game model: where is the rope, has someone won, are we
    // waiting for a release, and is this the re-arm cycle
    int m_pos;
    int m_low;
    bit m_won;
    bit m_wait;
    bit m_clr;
    bit m_prev;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        bit nclr;
        nclr = 1'b0;
        if (rst) begin
            m_pos  = 3;
            m_won  = 1'b0;
            m_wait = 1'b0;
            m_clr  = 1'b1;
            m_low  = 0;
            m_prev = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (m_won) begin
                nclr = 1'b1;
            end else if (m_clr) begin
                nclr = 1'b0;
            end else if (m_wait) begin
                m_low = push ? 0 : m_low + 1;
                if (m_low == 16) begin
                    m_wait = 1'b0;
                    nclr   = 1'b1;
                end
            end else if (push && !m_prev) begin
                if (!tie) m_pos = right ? m_pos + 1 : m_pos - 1;
                if (m_pos == 0 || m_pos == 6) begin
                    m_won = 1'b1;
                    nclr  = 1'b1;
                end else begin
                    m_wait = 1'b1;
                    m_low  = 0;
                end
            end
            m_clr  = nclr;
            m_prev = push;
        end
    end

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (chk_en) begin
            e        = '0;
            e[m_pos] = 1'b1;
            chk("model leds", leds, e);
            chk("model clr", 7'(clr), 7'(m_clr));
            chk("model win_left", 7'(win_left),
                7'(m_won && m_pos == 0));
            chk("model win_right", 7'(win_right),
                7'(m_won && m_pos == 6));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit p, input bit t, input bit r);
        push  = p;
        tie   = t;
        right = r;
    endtask

    task automatic press(input bit t, input bit r);
        drive(1'b1, t, r);
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int len;
        bit lvl;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("reset leds", leds, 7'b0001000);
        chk("reset clr", 7'(clr), 7'd1);
        chk("reset win_left", 7'(win_left), 7'd0);
        chk("reset win_right", 7'(win_right), 7'd0);
        rst = 1'b0;
        tick();
        chk("clr one cycle", 7'(clr), 7'd0);

        press(1'b0, 1'b1);
        chk("right move", leds, 7'b0010000);
        repeat (15) tick();
        chk("no early clr", 7'(clr), 7'd0);
        tick();
        chk("settle clr", 7'(clr), 7'd1);
        tick();
        chk("settle clr drop", 7'(clr), 7'd0);

        press(1'b1, 1'b1);
        chk("tie no move", leds, 7'b0010000);
        repeat (16) tick();
        chk("tie clr", 7'(clr), 7'd1);
        tick();

        press(1'b0, 1'b1);
        chk("second right", leds, 7'b0100000);
        repeat (10) tick();
        push = 1'b1;
        tick();
        push = 1'b0;
        repeat (15) tick();
        chk("bounce no clr", 7'(clr), 7'd0);
        tick();
        chk("bounce clr", 7'(clr), 7'd1);
        chk("bounce no move", leds, 7'b0100000);
        tick();

        repeat (4) begin
            press(1'b0, 1'b0);
            repeat (17) tick();
        end
        chk("left walk", leds, 7'b0000010);
        press(1'b0, 1'b0);
        chk("win leds", leds, 7'b0000001);
        chk("win_left set", 7'(win_left), 7'd1);
        chk("win_right clear", 7'(win_right), 7'd0);
        chk("win clr held", 7'(clr), 7'd1);
        repeat (3) begin
            press(1'b0, 1'b1);
            tick();
        end
        chk("win frozen", leds, 7'b0000001);
        chk("win sticky", 7'(win_left), 7'd1);
        rst = 1'b1;
        tick();
        chk("rst from win", leds, 7'b0001000);
        chk("rst win clear", 7'(win_left), 7'd0);
        rst = 1'b0;
        tick();

        press(1'b0, 1'b1);
        chk("pre-rst move", leds, 7'b0010000);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid-settle rst leds", leds, 7'b0001000);
        chk("mid-settle rst clr", 7'(clr), 7'd1);
        rst = 1'b0;
        tick();
        chk("post-rst ready", 7'(clr), 7'd0);
        press(1'b0, 1'b1);
        chk("post-rst move", leds, 7'b0010000);
        repeat (17) tick();

        for (int s = 0; s < 400; s++) begin
            lvl = s[0];
            len = lvl ? $urandom_range(1, 4) : $urandom_range(1, 22);
            for (int c = 0; c < len; c++) begin
                push  = lvl;
                tie   = ($urandom % 4) == 0;
                right = $urandom % 2;
                rst   = ($urandom % 300) == 0;
                tick();
            end
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tow_scorer.md
# tow_scorer

Downstream consumer of the push-button arbitration stage (`PBL`) in the Tug-of-War design. It takes each arbitrated `push`/`tie`/`right` outcome and moves the rope marker one position left or right across an LED bar. It detects a win at either end and latches it until reset. It also drives the `clr` that re-arms the arbitration latches, but only after both buttons have been released for a settle window.

## Interface
- `NUM_POS`, 7: LED positions; must be odd and ≥3. Centre = (NUM_POS-1)/2.
- `SETTLE_CYC`, 16: consecutive cycles `push` must be low before a `clr` pulse is issued; ≥1.
- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  level from arbitration stage: a button is down.
- `tie`  in  1  both buttons seen together; no movement.
- `right`  in  1  right player won arbitration; 0 with `push`=1 and `tie`=0 means left won.
- `clr`  out  1  registered; clears arbitration latches.
- `leds`  out  NUM_POS  registered, one-hot marker; bit 0 is the left end.
- `win_left`  out  1  registered, sticky left-win flag.
- `win_right`  out  1  registered, sticky right-win flag.

## Operation
- States:
  - CLEAR: `clr`=1 for exactly one cycle, then go to READY.
  - READY: waiting for a push edge.
  - SETTLE: waiting for release.
  - WIN: terminal.
- Reset (`rst`=1 at an edge):
  - state=CLEAR, pos=centre, `leds`=one-hot centre, `clr`=1, `win_left`=`win_right`=0, push_q=0, settle count=0.
- READY, push edge (push_q=0, `push`=1) — `tie`/`right` are sampled in this same cycle:
  - `tie`=1: pos unchanged.
  - else `right`=1: pos+1.
  - else: pos−1.
  - Next state is SETTLE, unless the new pos is 0 or NUM_POS−1, in which case go to WIN.
- SETTLE:
  - The counter increments while `push`=0.
  - Any cycle with `push`=1 resets the counter to 0.
  - When the counter reaches SETTLE_CYC−1 with `push`=0, go to CLEAR.
  - Presses during SETTLE are ignored and produce no movement.
- WIN:
  - pos is frozen; `win_left`=1 if pos=0, `win_right`=1 if pos=NUM_POS−1, never both.
  - `clr` is held at 1 so the buttons stay disarmed.
  - Only `rst` exits WIN.
- pos width: $clog2(NUM_POS) unsigned. No wrap-around is possible, because WIN is entered on reaching either end.
- `leds` always equals one-hot(pos), registered alongside pos.
- push_q is updated every cycle from `push`, in all states.

## Timing
- Push-edge-to-`leds` update latency: 1 cycle; `leds` changes on the edge after the cycle in which push_q=0 and `push`=1.
- Win flag asserts in the same cycle that `leds` reaches the end position.
- Release-to-`clr` latency: SETTLE_CYC cycles of continuous low `push`, then `clr`=1 for exactly 1 cycle.
- After the CLEAR cycle, a new edge is accepted from the first READY cycle onward. Because upstream gates `push` with ~`clr`, a button still held through CLEAR produces an edge; this counts as a new press.
- `rst` mid-SETTLE or mid-WIN: the next cycle shows the reset values, with no partial `clr`.
- `push` is assumed synchronous to `clk`; synchronisation is upstream.

## Structure
- Shared package `tow_pkg`:
  - state encoding constants (CLEAR, READY, SETTLE, WIN)
  - centre-position function
  - NUM_POS default
- Single flat module; the settle counter is small enough to inline. No sub-module.

## Test plan
- Reset, then release → `leds`=7'b0001000, `clr`=1 for exactly 1 cycle, flags 0.
- Right press (`push`=1, `right`=1, `tie`=0), release for 16 cycles → `leds`=7'b0010000 one cycle after the edge; `clr` pulses on the 17th low cycle.
- Tie press → `leds` unchanged, `clr` still pulses after settle.
- Bounce during settle: `push` low 10 cycles, high 1 cycle, low 16 cycles → no `clr` until 16 consecutive low cycles; no extra movement.
- Three left presses from centre → `leds`=7'b0000001, `win_left`=1, `clr` held 1; further presses cause no change; `rst` restores the centre.
- `rst` asserted during SETTLE after one right move → next cycle `leds`=centre, `clr`=1, counter cleared.
